// File: rtl/uart_frame_loader.sv
// Moves received UART bytes into the image RAM (load) and streams the
// RAM back out through the UART transmitter (dump).
module uart_frame_loader #(
  parameter int ADDR_W    = 16,
  parameter int NUM_BYTES = 65536
) (
  input  logic              clk_,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              rx_rdy_clr,
  input  logic              tx_busy,
  output logic              tx_wr_en,
  output logic [7:0]        tx_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  input  logic              dump_start,
  output logic              load_done,
  output logic              dump_done,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE,
    LD_WR,
    DP_RD,
    DP_LAT,
    DP_REQ,
    DP_WAIT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_BYTES - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic              clr_guard;

  assign mem_addr = cnt;

  always_ff @(posedge clk_ or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      clr_guard  <= 1'b0;
      rx_rdy_clr <= 1'b0;
      tx_wr_en   <= 1'b0;
      tx_data    <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      load_done  <= 1'b0;
      dump_done  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      load_done  <= 1'b0;
      dump_done  <= 1'b0;
      mem_we     <= 1'b0;
      rx_rdy_clr <= 1'b0;
      clr_guard  <= 1'b0;
      unique case (state)
        IDLE: begin
          // rx_rdy right after a write is the stale flag still clearing
          if (rx_rdy && !clr_guard) begin
            mem_wdata  <= rx_data;
            mem_we     <= 1'b1;
            rx_rdy_clr <= 1'b1;
            busy       <= 1'b1;
            state      <= LD_WR;
          end else if (dump_start && cnt == '0) begin
            busy  <= 1'b1;
            state <= DP_RD;
          end
        end
        LD_WR: begin
          clr_guard <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
          if (cnt == LAST) begin
            cnt       <= '0;
            load_done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DP_RD: state <= DP_LAT;
        DP_LAT: begin
          tx_data  <= mem_rdata;
          tx_wr_en <= 1'b1;
          state    <= DP_REQ;
        end
        DP_REQ: begin
          if (tx_busy) begin
            tx_wr_en <= 1'b0;
            state    <= DP_WAIT;
          end
        end
        DP_WAIT: begin
          if (!tx_busy) begin
            if (cnt == LAST) begin
              cnt       <= '0;
              dump_done <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= DP_RD;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Scoreboard bench for uart_frame_loader: RAM, receiver and
// transmitter models around a 4-byte frame.
module tb_uart_frame_loader;

  localparam int AW = 4;
  localparam int NB = 4;

  logic          clk_ = 1'b0;
  logic          rst = 1'b1;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_rdy_clr;
  logic          tx_busy = 1'b0;
  logic          tx_wr_en;
  logic [7:0]    tx_data;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic [7:0]    mem_rdata;
  logic          dump_start = 1'b0;
  logic          load_done;
  logic          dump_done;
  logic          busy;

  uart_frame_loader #(.ADDR_W(AW), .NUM_BYTES(NB)) dut (
    .clk_(clk_),
    .rst(rst),
    .rx_rdy(rx_rdy),
    .rx_data(rx_data),
    .rx_rdy_clr(rx_rdy_clr),
    .tx_busy(tx_busy),
    .tx_wr_en(tx_wr_en),
    .tx_data(tx_data),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_rdata(mem_rdata),
    .dump_start(dump_start),
    .load_done(load_done),
    .dump_done(dump_done),
    .busy(busy)
  );

  always #5 clk_ = ~clk_;

  logic [7:0] ram [16];
  always_ff @(posedge clk_) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  typedef struct packed {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int n_run = 0;
  int n_fail = 0;
  int n_clr = 0;
  int n_ld = 0;
  int n_dn = 0;
  logic tx_hold = 1'b0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(string nm);
    n_run++;
    n_fail++;
    $display("FAIL %s: got event expected none", nm);
  endtask

  // monitor / scoreboard
  initial begin
    logic wr_prev;
    logic bz_prev;
    wr_t  w;
    logic [7:0] t;
    wr_prev = 1'b0;
    bz_prev = 1'b0;
    forever begin
      @(posedge clk_);
      #1;
      if (rx_rdy_clr) n_clr++;
      if (load_done) n_ld++;
      if (dump_done) n_dn++;
      if (load_done || dump_done)
        chk("done_excl", 32'(load_done & dump_done), 0);
      if (mem_we) begin
        if (exp_wr.size() == 0) fail("wr_unexpected");
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(mem_addr), 32'(w.a));
          chk("wr_data", 32'(mem_wdata), 32'(w.d));
          chk("wr_clr", 32'(rx_rdy_clr), 1);
        end
      end
      if (tx_wr_en && !wr_prev) begin
        if (exp_tx.size() == 0) fail("tx_unexpected");
        else begin
          t = exp_tx.pop_front();
          chk("tx_data", 32'(tx_data), 32'(t));
        end
      end
      if (tx_busy && !bz_prev) chk("tx_drop", 32'(tx_wr_en), 0);
      wr_prev = tx_wr_en;
      bz_prev = tx_busy;
    end
  end

  // transmitter: busy for 10 clocks per accepted byte
  initial begin
    forever begin
      @(negedge clk_);
      if (tx_wr_en && !tx_busy && !tx_hold) begin
        tx_busy = 1'b1;
        repeat (10) @(negedge clk_);
        tx_busy = 1'b0;
      end
    end
  end

  task automatic raise_rx(logic [7:0] b);
    @(negedge clk_);
    rx_data = b;
    rx_rdy = 1'b1;
  endtask

  task automatic wait_clr(int bound);
    int k = 0;
    while (!rx_rdy_clr && k < bound) begin
      @(negedge clk_);
      k++;
    end
    if (!rx_rdy_clr) chk("clr_timeout", 0, 1);
    rx_rdy = 1'b0;
  endtask

  task automatic send(logic [3:0] a, logic [7:0] b);
    exp_wr.push_back({a, b});
    raise_rx(b);
    wait_clr(20);
  endtask

  task automatic pulse_dump();
    @(negedge clk_);
    dump_start = 1'b1;
    @(negedge clk_);
    dump_start = 1'b0;
  endtask

  task automatic wait_dn(int bound);
    int k = 0;
    while (k < bound) begin
      @(posedge clk_);
      #1;
      if (dump_done) break;
      k++;
    end
    if (k >= bound) chk("dn_timeout", 0, 1);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, "_addr"}, 32'(mem_addr), 0);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_txd"}, 32'(tx_data), 0);
    chk({nm, "_we"}, 32'(mem_we), 0);
    chk({nm, "_wren"}, 32'(tx_wr_en), 0);
    chk({nm, "_clr"}, 32'(rx_rdy_clr), 0);
  endtask

  initial begin
    int c0;
    int k;
    repeat (2) @(negedge clk_);
    chk_zero("rst");
    chk("rst_ld", 32'(load_done), 0);
    chk("rst_dn", 32'(dump_done), 0);
    rst = 1'b0;

    // load a full frame
    send(0, 8'h11);
    send(1, 8'h22);
    send(2, 8'h33);
    send(3, 8'h44);
    repeat (3) @(negedge clk_);
    chk("t1_ld", n_ld, 1);
    chk("t1_clr", n_clr, 4);
    chk("t1_cnt", 32'(mem_addr), 0);
    chk("t1_busy", 32'(busy), 0);

    // dump it back
    exp_tx.push_back(8'h11);
    exp_tx.push_back(8'h22);
    exp_tx.push_back(8'h33);
    exp_tx.push_back(8'h44);
    pulse_dump();
    wait_dn(400);
    @(negedge clk_);
    chk("t2_dn", n_dn, 1);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_txq", exp_tx.size(), 0);

    // rx wins over dump; dump ignored mid-frame
    exp_wr.push_back({4'd0, 8'h55});
    @(negedge clk_);
    rx_data = 8'h55;
    rx_rdy = 1'b1;
    dump_start = 1'b1;
    wait_clr(20);
    repeat (3) @(negedge clk_);
    dump_start = 1'b0;
    chk("t3_busy", 32'(busy), 0);
    chk("t3_cnt", 32'(mem_addr), 1);
    send(1, 8'h66);
    repeat (2) @(negedge clk_);
    dump_start = 1'b1;
    repeat (6) @(negedge clk_);
    chk("t3_ign_busy", 32'(busy), 0);
    chk("t3_ign_wren", 32'(tx_wr_en), 0);
    dump_start = 1'b0;
    send(2, 8'h77);
    send(3, 8'h88);
    repeat (3) @(negedge clk_);
    chk("t3_ld", n_ld, 2);

    // pending rx during dump
    exp_tx.push_back(8'h55);
    exp_tx.push_back(8'h66);
    exp_tx.push_back(8'h77);
    exp_tx.push_back(8'h88);
    exp_wr.push_back({4'd0, 8'h99});
    pulse_dump();
    repeat (15) @(negedge clk_);
    rx_data = 8'h99;
    rx_rdy = 1'b1;
    c0 = n_clr;
    wait_dn(400);
    chk("t4_noclr", n_clr, c0);
    wait_clr(20);
    repeat (3) @(negedge clk_);
    chk("t4_cnt", 32'(mem_addr), 1);
    chk("t4_dn", n_dn, 2);

    // async reset mid-load
    send(1, 8'haa);
    repeat (2) @(negedge clk_);
    chk("t5_pre", 32'(mem_addr), 2);
    @(posedge clk_);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("t5");
    @(negedge clk_);
    rst = 1'b0;
    c0 = n_ld;
    send(0, 8'hbb);
    repeat (3) @(negedge clk_);
    chk("t5_ld", n_ld, c0);
    chk("t5_cnt", 32'(mem_addr), 1);

    // request held while transmitter stays idle
    send(1, 8'hcc);
    send(2, 8'hdd);
    send(3, 8'hee);
    repeat (3) @(negedge clk_);
    exp_tx.push_back(8'hbb);
    exp_tx.push_back(8'hcc);
    exp_tx.push_back(8'hdd);
    exp_tx.push_back(8'hee);
    tx_hold = 1'b1;
    pulse_dump();
    k = 0;
    while (!tx_wr_en && k < 20) begin
      @(negedge clk_);
      k++;
    end
    chk("t6_req", 32'(tx_wr_en), 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_);
      chk("t6_hold_wren", 32'(tx_wr_en), 1);
      chk("t6_hold_data", 32'(tx_data), 32'h bb);
    end
    tx_hold = 1'b0;
    wait_dn(400);
    repeat (2) @(negedge clk_);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_dn", n_dn, 3);
    chk("end_txq", exp_tx.size(), 0);
    chk("end_wrq", exp_wr.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
